// File: rtl/huffman_symbol_sequencer_if.sv
// ---------------------------------------------------------------------------
// huffman_symbol_sequencer_if
//   Bundles the block-input handshake and the symbol-output handshake of the
//   Huffman symbol sequencer.
//
//   Block side : zigzag_pix_in, blk_valid, blk_ready, dc_pred_clr
//   Symbol side: sym_valid, sym_ready, sym_is_dc, sym_run, sym_size,
//                sym_amp, sym_last
//   Status     : busy
//
//   master : upstream / downstream environment (drives block, accepts symbols)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface huffman_symbol_sequencer_if #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 64,
    parameter int AMP_W = PIX_W + 1
);
    logic [NPIX*PIX_W-1:0] zigzag_pix_in;
    logic                  blk_valid;
    logic                  blk_ready;
    logic                  dc_pred_clr;
    logic                  sym_valid;
    logic                  sym_ready;
    logic                  sym_is_dc;
    logic [3:0]            sym_run;
    logic [3:0]            sym_size;
    logic [AMP_W-1:0]      sym_amp;
    logic                  sym_last;
    logic                  busy;

    modport master (
        output zigzag_pix_in, blk_valid, dc_pred_clr, sym_ready,
        input  blk_ready, sym_valid, sym_is_dc, sym_run, sym_size,
               sym_amp, sym_last, busy
    );

    modport slave (
        input  zigzag_pix_in, blk_valid, dc_pred_clr, sym_ready,
        output blk_ready, sym_valid, sym_is_dc, sym_run, sym_size,
               sym_amp, sym_last, busy
    );
endinterface

// File: rtl/huffman_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// huffman_symbol_sequencer
//   Walks one zig-zag ordered block of NPIX coefficients and issues the JPEG
//   baseline symbol stream: one DC difference, then AC (run,size,amp)
//   symbols, ZRL (15/0) for runs of 16+ zeros ahead of a nonzero
//   coefficient, and EOB (0/0) when the block ends in zeros. Owns the DC
//   predictor. One coefficient is scanned per clock.
//
// Ports
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   seq      slave modport of huffman_symbol_sequencer_if:
//              zigzag_pix_in / blk_valid / blk_ready  block input handshake
//              dc_pred_clr                            zero the DC predictor
//              sym_valid / sym_ready                  symbol handshake
//              sym_is_dc, sym_run, sym_size, sym_amp, sym_last  symbol
//              busy                                   block in progress
// ---------------------------------------------------------------------------
module huffman_symbol_sequencer #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 64,
    parameter int AMP_W = PIX_W + 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    huffman_symbol_sequencer_if.slave    seq
);

    localparam int                IDX_W    = $clog2(NPIX);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [IDX_W-1:0]  ZRL_LEN  = IDX_W'(16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC,
        S_SCAN,
        S_ZRL,
        S_AC,
        S_EOB
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic signed [PIX_W-1:0]  r_coef [NPIX];
    logic signed [PIX_W-1:0]  r_pred;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_run;

    logic signed [PIX_W-1:0]  w_cur_coef;
    logic                     w_cur_zero;
    logic                     w_hs;
    logic                     w_accept;
    logic [IDX_W-1:0]         w_run_after_zrl;
    logic signed [AMP_W-1:0]  w_dc_diff;
    logic signed [AMP_W-1:0]  w_val;
    logic [AMP_W-1:0]         w_mag;
    logic [AMP_W-1:0]         w_val_dec;
    logic [AMP_W-1:0]         w_mask;
    logic [AMP_W-1:0]         w_amp;
    logic [3:0]               w_size;

    // ---------------------------------------------------------------------
    // Shared datapath
    // ---------------------------------------------------------------------
    assign w_cur_coef      = r_coef[r_idx];
    assign w_cur_zero      = (w_cur_coef == '0);
    assign w_hs            = seq.sym_valid && seq.sym_ready;
    assign w_accept        = (r_state == S_IDLE) && seq.blk_valid;
    assign w_run_after_zrl = r_run - ZRL_LEN;

    // Both operands sign-extend to AMP_W bits, so the difference never wraps.
    assign w_dc_diff = AMP_W'(r_coef[0]) - AMP_W'(r_pred);
    assign w_val     = (r_state == S_DC) ? w_dc_diff : AMP_W'(w_cur_coef);

    // Magnitude category and amplitude bits; negative values send the low
    // bits of (v-1), i.e. the one's complement of |v|.
    assign w_mag     = w_val[AMP_W-1] ? AMP_W'(-w_val) : AMP_W'(w_val);
    assign w_val_dec = w_val - AMP_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_size = '0;
        for (int i = 0; i < AMP_W; i++) begin
            if (w_mag[i]) begin
                w_size = 4'(i + 1);
            end
        end
    end

    // A shift of AMP_W clears every bit, so size == AMP_W keeps the full word.
    assign w_mask = ~({AMP_W{1'b1}} << w_size);
    assign w_amp  = (w_val[AMP_W-1] ? w_val_dec : AMP_W'(w_val)) & w_mask;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (seq.blk_valid) w_next_state = S_DC;
            S_DC:   if (w_hs)          w_next_state = S_SCAN;
            S_SCAN: begin
                if (!w_cur_zero) begin
                    w_next_state = (r_run >= ZRL_LEN) ? S_ZRL : S_AC;
                end else if (r_idx == LAST_IDX) begin
                    w_next_state = S_EOB;
                end
            end
            S_ZRL: begin
                if (w_hs && (w_run_after_zrl < ZRL_LEN)) begin
                    w_next_state = S_AC;
                end
            end
            S_AC: begin
                if (w_hs) begin
                    w_next_state = (r_idx == LAST_IDX) ? S_IDLE : S_SCAN;
                end
            end
            S_EOB:  if (w_hs) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (pure function of registered state, so they stay stable
    // while a symbol is stalled)
    // ---------------------------------------------------------------------
    always_comb begin
        seq.blk_ready = (r_state == S_IDLE);
        seq.busy      = (r_state != S_IDLE);
        seq.sym_valid = 1'b0;
        seq.sym_is_dc = 1'b0;
        seq.sym_run   = '0;
        seq.sym_size  = '0;
        seq.sym_amp   = '0;
        seq.sym_last  = 1'b0;
        case (r_state)
            S_DC: begin
                seq.sym_valid = 1'b1;
                seq.sym_is_dc = 1'b1;
                seq.sym_size  = w_size;
                seq.sym_amp   = w_amp;
            end
            S_ZRL: begin
                seq.sym_valid = 1'b1;
                seq.sym_run   = 4'd15;
            end
            S_AC: begin
                // Run is always below 16 here; longer runs were drained by ZRL.
                seq.sym_valid = 1'b1;
                seq.sym_run   = r_run[3:0];
                seq.sym_size  = w_size;
                seq.sym_amp   = w_amp;
                seq.sym_last  = (r_idx == LAST_IDX);
            end
            S_EOB: begin
                seq.sym_valid = 1'b1;
                seq.sym_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Scan index, zero run and DC predictor
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_run  <= '0;
            r_pred <= '0;
        end else begin
            case (r_state)
                S_DC: begin
                    if (w_hs) begin
                        r_idx <= IDX_W'(1);
                        r_run <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_cur_zero && (r_idx != LAST_IDX)) begin
                        r_run <= r_run + IDX_W'(1);
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_ZRL: begin
                    if (w_hs) r_run <= w_run_after_zrl;
                end
                S_AC: begin
                    if (w_hs) begin
                        r_run <= '0;
                        if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase

            // Restart-interval clear wins over storing this block's DC.
            if (seq.dc_pred_clr) begin
                r_pred <= '0;
            end else if ((r_state == S_DC) && w_hs) begin
                r_pred <= r_coef[0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Coefficient store
    // ---------------------------------------------------------------------
    // NOTE: the coefficient array is deliberately not reset: it is only read
    // after a block has been latched, so a reset would cost flops for nothing.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int k = 0; k < NPIX; k++) begin
                r_coef[k] <= seq.zigzag_pix_in[k*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// tb_huffman_symbol_sequencer
//   Table of hand-derived blocks, hand-written corner sequences (stalled ZRL,
//   predictor clear, reset mid-scan) and randomized blocks checked against a
//   behavioural JPEG symbol model.
// ---------------------------------------------------------------------------
module tb_huffman_symbol_sequencer;

    localparam int PIX_W = 8;
    localparam int NPIX  = 64;
    localparam int AMP_W = 9;

    typedef struct packed {
        logic             is_dc;
        logic [3:0]       run;
        logic [3:0]       size;
        logic [AMP_W-1:0] amp;
        logic             last;
    } sym_t;

    typedef struct packed {
        logic [7:0]       c0;
        logic [1:0]       n_nz;
        logic [1:0][5:0]  nz_idx;
        logic [1:0][7:0]  nz_val;
        logic [2:0]       n_sym;
        sym_t [5:0]       exp;
    } vec_t;

    logic clock;
    logic reset_n;

    huffman_symbol_sequencer_if #(.PIX_W(PIX_W), .NPIX(NPIX), .AMP_W(AMP_W)) bus ();

    huffman_symbol_sequencer #(.PIX_W(PIX_W), .NPIX(NPIX), .AMP_W(AMP_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .seq     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_errors = 0;
    sym_t exp_q[$];
    int   model_pred = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic sym_t S(input logic d, input int r, input int sz, input int a, input logic l);
        sym_t s;
        s.is_dc = d;
        s.run   = 4'(r);
        s.size  = 4'(sz);
        s.amp   = AMP_W'(a);
        s.last  = l;
        return s;
    endfunction

    // JPEG category/amplitude from the value's arithmetic definition.
    function automatic sym_t mk(input logic d, input int r, input int v, input logic l);
        int m;
        int size;
        int amp;
        m    = (v < 0) ? -v : v;
        size = 0;
        while (m > 0) begin
            size++;
            m = m >> 1;
        end
        amp = (v >= 0) ? v : v + (1 << size) - 1;
        return S(d, r, size, amp, l);
    endfunction

    function automatic sym_t cur_sym();
        sym_t s;
        s.is_dc = bus.sym_is_dc;
        s.run   = bus.sym_run;
        s.size  = bus.sym_size;
        s.amp   = bus.sym_amp;
        s.last  = bus.sym_last;
        return s;
    endfunction

    // Expected symbol stream for one block, using model_pred, then updates it.
    function automatic void model_block(input logic [NPIX*PIX_W-1:0] pix);
        int c[NPIX];
        int run;
        int last_nz;
        for (int k = 0; k < NPIX; k++) c[k] = int'($signed(pix[k*PIX_W +: PIX_W]));
        exp_q.push_back(mk(1'b1, 0, c[0] - model_pred, 1'b0));
        run     = 0;
        last_nz = 0;
        for (int k = 1; k < NPIX; k++) begin
            if (c[k] == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(S(1'b0, 15, 0, 0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(mk(1'b0, run, c[k], k == NPIX - 1));
                run     = 0;
                last_nz = k;
            end
        end
        if (last_nz != NPIX - 1) exp_q.push_back(S(1'b0, 0, 0, 0, 1'b1));
        model_pred = c[0];
    endfunction

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on the first ZRL
    task automatic run_block(input logic [NPIX*PIX_W-1:0] pix, input bit clr,
                             input int mode, input string tag);
        sym_t held;
        sym_t cur;
        sym_t e;
        bit   have_held;
        bit   done;
        bit   rdy;
        int   cycles;
        int   stall_cnt;
        @(negedge clock);
        check({tag, "_blk_ready_before"}, 32'(bus.blk_ready), 32'd1);
        bus.zigzag_pix_in = pix;
        bus.blk_valid     = 1'b1;
        bus.dc_pred_clr   = clr;
        @(negedge clock);
        bus.blk_valid   = 1'b0;
        bus.dc_pred_clr = 1'b0;
        check({tag, "_dc_latency"},
              32'({bus.sym_valid, bus.sym_is_dc, bus.busy, bus.blk_ready}), 32'b1110);
        have_held = 1'b0;
        done      = 1'b0;
        cycles    = 0;
        stall_cnt = 0;
        while (!done && cycles < 400) begin
            cur = cur_sym();
            if (have_held) check({tag, "_hold"}, 32'({bus.sym_valid, cur}), 32'({1'b1, held}));
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bus.sym_valid && !cur.is_dc && cur.run == 4'd15 && cur.size == 4'd0
                        && !cur.last && stall_cnt < 5) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            bus.sym_ready = rdy;
            if (bus.sym_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s_extra_symbol: got 0x%0h, expected none", tag, cur);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_sym"}, 32'(cur), 32'(e));
                end
                if (cur.last) done = 1'b1;
                have_held = 1'b0;
            end else if (bus.sym_valid) begin
                held      = cur;
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        bus.sym_ready = 1'b0;
        check({tag, "_finished_in_budget"}, 32'(done), 32'd1);
        check({tag, "_idle_after_last"},
              32'({bus.blk_ready, bus.busy, bus.sym_valid}), 32'b100);
        check({tag, "_no_missing_symbols"}, 32'(exp_q.size()), 32'd0);
        if (mode == 2) check({tag, "_zrl_stalled"}, 32'(stall_cnt), 32'd5);
        exp_q.delete();
    endtask

    vec_t                  tbl[5];
    logic [NPIX*PIX_W-1:0] pix;

    initial begin
        // ---------------- table of hand-derived blocks ----------------
        for (int i = 0; i < 5; i++) tbl[i] = '0;
        // all-zero block, predictor 0
        tbl[0].c0 = 8'd0;  tbl[0].n_sym = 3'd2;
        tbl[0].exp[0] = S(1, 0, 0, 0, 0);  tbl[0].exp[1] = S(0, 0, 0, 0, 1);
        // DC 5 from predictor 0
        tbl[1].c0 = 8'd5;  tbl[1].n_sym = 3'd2;
        tbl[1].exp[0] = S(1, 0, 3, 5, 0);  tbl[1].exp[1] = S(0, 0, 0, 0, 1);
        // DC 3 from predictor 5 -> diff -2
        tbl[2].c0 = 8'd3;  tbl[2].n_sym = 3'd2;
        tbl[2].exp[0] = S(1, 0, 2, 1, 0);  tbl[2].exp[1] = S(0, 0, 0, 0, 1);
        // coeff1=-1, coeff20=7, diff 0
        tbl[3].c0 = 8'd3;  tbl[3].n_nz = 2'd2; tbl[3].n_sym = 3'd5;
        tbl[3].nz_idx[0] = 6'd1;  tbl[3].nz_val[0] = 8'hFF;
        tbl[3].nz_idx[1] = 6'd20; tbl[3].nz_val[1] = 8'd7;
        tbl[3].exp[0] = S(1, 0, 0, 0, 0);   tbl[3].exp[1] = S(0, 0, 1, 0, 0);
        tbl[3].exp[2] = S(0, 15, 0, 0, 0);  tbl[3].exp[3] = S(0, 2, 3, 7, 0);
        tbl[3].exp[4] = S(0, 0, 0, 0, 1);
        // coeff63=-128, diff 0
        tbl[4].c0 = 8'd3;  tbl[4].n_nz = 2'd1; tbl[4].n_sym = 3'd5;
        tbl[4].nz_idx[0] = 6'd63; tbl[4].nz_val[0] = 8'h80;
        tbl[4].exp[0] = S(1, 0, 0, 0, 0);   tbl[4].exp[1] = S(0, 15, 0, 0, 0);
        tbl[4].exp[2] = S(0, 15, 0, 0, 0);  tbl[4].exp[3] = S(0, 15, 0, 0, 0);
        tbl[4].exp[4] = S(0, 14, 8, 'h7F, 1);

        // ---------------- reset ----------------
        reset_n           = 1'b0;
        bus.zigzag_pix_in = '0;
        bus.blk_valid     = 1'b0;
        bus.dc_pred_clr   = 1'b0;
        bus.sym_ready     = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_ctrl", 32'({bus.blk_ready, bus.busy, bus.sym_valid}), 32'b100);
        check("reset_sym", 32'(cur_sym()), 32'd0);
        reset_n = 1'b1;

        // ---------------- table-driven blocks ----------------
        for (int i = 0; i < 5; i++) begin
            pix = '0;
            pix[7:0] = tbl[i].c0;
            for (int j = 0; j < int'(tbl[i].n_nz); j++)
                pix[int'(tbl[i].nz_idx[j])*PIX_W +: PIX_W] = tbl[i].nz_val[j];
            for (int j = 0; j < int'(tbl[i].n_sym); j++) exp_q.push_back(tbl[i].exp[j]);
            run_block(pix, 1'b0, i % 2, $sformatf("tbl%0d", i));
            model_pred = int'($signed(tbl[i].c0));
        end

        // ---------------- stalled ZRL (pred is 3, same block as tbl3) ----------------
        pix = '0;
        pix[7:0] = 8'd3;
        pix[1*PIX_W +: PIX_W]  = 8'hFF;
        pix[20*PIX_W +: PIX_W] = 8'd7;
        for (int j = 0; j < 5; j++) exp_q.push_back(tbl[3].exp[j]);
        run_block(pix, 1'b0, 2, "zrl_stall");

        // ---------------- predictor clear ----------------
        pix = '0;
        pix[7:0] = 8'd5;
        exp_q.push_back(S(1, 0, 2, 2, 0));        // 5 - 3
        exp_q.push_back(S(0, 0, 0, 0, 1));
        run_block(pix, 1'b0, 0, "clr_first");
        @(negedge clock);
        bus.dc_pred_clr = 1'b1;
        @(negedge clock);
        bus.dc_pred_clr = 1'b0;
        exp_q.push_back(S(1, 0, 3, 5, 0));        // predictor cleared, not 0 diff
        exp_q.push_back(S(0, 0, 0, 0, 1));
        run_block(pix, 1'b0, 0, "clr_idle");
        exp_q.push_back(S(1, 0, 3, 5, 0));        // clear together with accept
        exp_q.push_back(S(0, 0, 0, 0, 1));
        run_block(pix, 1'b1, 1, "clr_accept");

        // ---------------- reset mid-SCAN ----------------
        pix = '0;
        pix[7:0] = 8'd1;
        pix[50*PIX_W +: PIX_W] = 8'd1;
        @(negedge clock);
        bus.zigzag_pix_in = pix;
        bus.blk_valid     = 1'b1;
        @(negedge clock);
        bus.blk_valid = 1'b0;
        bus.sym_ready = 1'b1;
        @(negedge clock);
        bus.sym_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("scan_in_progress", 32'({bus.busy, bus.sym_valid}), 32'b10);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_ctrl", 32'({bus.blk_ready, bus.busy, bus.sym_valid}), 32'b100);
        check("midreset_sym", 32'(cur_sym()), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pix = '0;
        pix[7:0] = 8'd5;
        exp_q.push_back(S(1, 0, 3, 5, 0));        // predictor back to 0
        exp_q.push_back(S(0, 0, 0, 0, 1));
        run_block(pix, 1'b0, 0, "after_reset");
        model_pred = 5;

        // ---------------- randomized blocks vs model ----------------
        for (int b = 0; b < 40; b++) begin
            bit clr;
            for (int k = 0; k < NPIX; k++)
                pix[k*PIX_W +: PIX_W] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'd0;
            if (b % 4 == 0) pix[0 +: PIX_W] = 8'($urandom);
            if (b % 5 == 0) pix[63*PIX_W +: PIX_W] = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'd127;
            if (b % 7 == 3) pix[PIX_W +: 56*PIX_W] = '0;  // long zero runs
            clr = ($urandom_range(0, 4) == 0);
            if (clr) model_pred = 0;
            model_block(pix);
            run_block(pix, clr, 1, $sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
